// File: rtl/eval_unit_arbiter_if.sv
// Bundle of every handshake and data signal between the requester clients,
// the shared evaluation unit and the arbiter.
//   master : client / evaluation-unit side (drives requests, eu results, rsp_ready)
//   slave  : arbiter side (drives grants, eu operands, responses, status)
// Signals:
//   req_valid/req_ready       per-requester handshake, NREQ bits each
//   req_in1..3                packed operands, requester i at [i*W +: W]
//   eu_in1..3 / eu_out1..2    operands to / results from the evaluation unit
//   rsp_valid/rsp_ready       response handshake
//   rsp_id, rsp_out1..2       response tag and captured results
//   busy, done_cnt            status
interface eval_unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 3
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_in1;
    logic [NREQ*W-1:0] req_in2;
    logic [NREQ*W-1:0] req_in3;
    logic [W-1:0]      eu_in1;
    logic [W-1:0]      eu_in2;
    logic [W-1:0]      eu_in3;
    logic [W-1:0]      eu_out1;
    logic [W-1:0]      eu_out2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_out1;
    logic [W-1:0]      rsp_out2;
    logic              busy;
    logic [15:0]       done_cnt;

    modport master (
        output req_valid, req_in1, req_in2, req_in3, eu_out1, eu_out2, rsp_ready,
        input  req_ready, eu_in1, eu_in2, eu_in3, rsp_valid, rsp_id,
               rsp_out1, rsp_out2, busy, done_cnt
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_in3, eu_out1, eu_out2, rsp_ready,
        output req_ready, eu_in1, eu_in2, eu_in3, rsp_valid, rsp_id,
               rsp_out1, rsp_out2, busy, done_cnt
    );
endinterface

// File: rtl/eval_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 3-operand
// evaluation unit among NREQ requesters. One request is accepted at a time,
// its operands are registered and held on the unit, the two results are
// captured one cycle later and returned tagged with the requester index.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    eval_unit_arbiter_if.slave (request, unit and response signals)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for any req_valid; grant is combinational, accept on edge
// EVAL  | operand registers drive the unit; results captured on the edge
// RESP  | rsp_valid high, results and id held until rsp_ready
module eval_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    eval_unit_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   op2_q, op2_d;
    logic [W-1:0]   op3_q, op3_d;
    logic [W-1:0]   res1_q, res1_d;
    logic [W-1:0]   res2_q, res2_d;
    logic [15:0]    done_cnt_q, done_cnt_d;

    logic            found;
    logic [IDW-1:0]  grant;
    logic [IDW:0]    cand_sum;
    logic [IDW-1:0]  ptr_nxt;
    logic [W-1:0]    sel_in1, sel_in2, sel_in3;
    logic [NREQ-1:0] req_ready_c;

    // Round-robin search starting at ptr; candidate index wraps modulo NREQ,
    // which also covers non-power-of-two requester counts.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        cand_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_sum >= NREQ_W) begin
                cand_sum = cand_sum - NREQ_W;
            end
            if (!found && bus.req_valid[cand_sum[IDW-1:0]]) begin
                found = 1'b1;
                grant = cand_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_in1     = '0;
        sel_in2     = '0;
        sel_in3     = '0;
        req_ready_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_in1 = bus.req_in1[k*W +: W];
                sel_in2 = bus.req_in2[k*W +: W];
                sel_in3 = bus.req_in3[k*W +: W];
            end
            req_ready_c[k] = (state_q == IDLE) && found && (grant == IDW'(k));
        end
    end

    assign ptr_nxt = (grant == LAST_ID) ? '0 : grant + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        op3_d      = op3_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    op1_d   = sel_in1;
                    op2_d   = sel_in2;
                    op3_d   = sel_in3;
                    id_d    = grant;
                    ptr_d   = ptr_nxt;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                res1_d  = bus.eu_out1;
                res2_d  = bus.eu_out2;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done_cnt is rewritten every cycle (holding its value when idle) so the
    // register always reloads from its own current contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            op3_q      <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            op3_q      <= op3_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.eu_in1    = op1_q;
    assign bus.eu_in2    = op2_q;
    assign bus.eu_in3    = op3_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_out1  = res1_q;
    assign bus.rsp_out2  = res2_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_eval_unit_arbiter.sv
// Self-checking bench for eval_unit_arbiter: a transaction-level model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_eval_unit_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 3;

    logic clk;
    logic rst_n;

    eval_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    eval_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // evaluation-unit stub
    assign bus.eu_out1 = bus.eu_in1 + bus.eu_in2 + bus.eu_in3;
    assign bus.eu_out2 = bus.eu_in1 ^ bus.eu_in3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit m_busy = 0;       // a request is in flight
    bit m_vis  = 0;       // its response is visible
    int m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_c = 0, m_r1 = 0, m_r2 = 0, m_done = 0;
    int m_w;
    int m_log[$];
    int d_log[$];
    int d_cyc[$];

    function automatic int winner();
        logic [NREQ-1:0] s;
        for (int k = 0; k < NREQ; k++) begin
            s = bus.req_valid >> ((m_ptr + k) % NREQ);
            if (s[0]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int opnd(input logic [NREQ*W-1:0] v, input int i);
        logic [NREQ*W-1:0] t;
        t = v >> (i * W);
        return int'(t[W-1:0]);
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_vis = 0; m_ptr = 0; m_id = 0;
            m_a = 0; m_b = 0; m_c = 0; m_r1 = 0; m_r2 = 0; m_done = 0;
        end else if (!m_busy) begin
            m_w = winner();
            if (m_w >= 0) begin
                m_busy = 1;
                m_vis  = 0;
                m_id   = m_w;
                m_a    = opnd(bus.req_in1, m_w);
                m_b    = opnd(bus.req_in2, m_w);
                m_c    = opnd(bus.req_in3, m_w);
                m_ptr  = (m_w + 1) % NREQ;
                m_log.push_back(m_w);
            end
        end else if (!m_vis) begin
            m_vis = 1;
            m_r1  = (m_a + m_b + m_c) % 8;
            m_r2  = m_a ^ m_c;
        end else if (bus.rsp_ready) begin
            m_busy = 0;
            m_vis  = 0;
            m_done = (m_done + 1) % 65536;
        end
    end

    logic [NREQ-1:0] exp_rdy;
    int ew;
    always @(negedge clk) begin
        exp_rdy = '0;
        if (!m_busy) begin
            ew = winner();
            if (ew >= 0) exp_rdy = NREQ'(1) << ew;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_vis));
        chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
        chk("rsp_out1",  32'(bus.rsp_out1),  32'(m_r1));
        chk("rsp_out2",  32'(bus.rsp_out2),  32'(m_r2));
        chk("eu_in1",    32'(bus.eu_in1),    32'(m_a));
        chk("eu_in2",    32'(bus.eu_in2),    32'(m_b));
        chk("eu_in3",    32'(bus.eu_in3),    32'(m_c));
        chk("done_cnt",  32'(bus.done_cnt),  32'(m_done));
        if (rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ready[k]) begin
                    d_log.push_back(k);
                    d_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c);
        bus.req_in1[i*W +: W] = W'(a);
        bus.req_in2[i*W +: W] = W'(b);
        bus.req_in3[i*W +: W] = W'(c);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        sync();
    endtask

    // returns just before the accepting edge
    task automatic wait_grant(input int i);
        int found;
        found = 0;
        #1;
        for (int n = 0; n < 50 && found == 0; n++) begin
            if (bus.req_ready[i]) found = 1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        chk("grant_wait", 32'(found), 32'd1);
    endtask

    task automatic wait_log(input int n);
        int ok;
        ok = 0;
        for (int t = 0; t < 60 && ok == 0; t++) begin
            @(negedge clk);
            #1;
            if (d_log.size() >= n) ok = 1;
        end
        chk("log_wait", 32'(ok), 32'd1);
    endtask

    // raise req_valid[i], wait for grant, drop it after the accepting edge
    task automatic request_one(input int i, input int a, input int b, input int c);
        set_ops(i, a, b, c);
        bus.req_valid[i] = 1'b1;
        wait_grant(i);
        sync();
        bus.req_valid[i] = 1'b0;
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_fair[3] = '{1, 3, 1};

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        bus.req_in3 = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_done_cnt",  32'(bus.done_cnt), 32'd0);
        chk("rst_rsp_out1",  32'(bus.rsp_out1), 32'd0);
        chk("rst_eu_in1",    32'(bus.eu_in1), 32'd0);
        #1;
        rst_n = 1'b1;
        sync();

        // single request: (3,4,5) from requester 2 -> out1=4, out2=6
        bus.rsp_ready = 1'b1;
        request_one(2, 3, 4, 5);
        @(negedge clk); #1;
        chk("single_eval_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("single_eval_busy",      32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_id",    32'(bus.rsp_id), 32'd2);
        chk("single_rsp_out1",  32'(bus.rsp_out1), 32'd4);
        chk("single_rsp_out2",  32'(bus.rsp_out2), 32'd6);
        sync();
        chk("single_done_cnt",  32'(bus.done_cnt), 32'd1);
        chk("single_idle",      32'(bus.busy), 32'd0);

        // all four requesters from reset: order 0,1,2,3,0, 3 cycles apart
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, i, i + 1, 7 - i);
        d_log.delete();
        d_cyc.delete();
        m_log.delete();
        bus.req_valid = 4'hF;
        wait_log(5);
        sync();
        bus.req_valid = '0;
        repeat (4) sync();
        for (int k = 0; k < 5; k++) begin
            chk("rr_order_dut",   32'(k < d_log.size() ? d_log[k] : -1), 32'(exp_rr[k]));
            chk("rr_order_model", 32'(k < m_log.size() ? m_log[k] : -1), 32'(exp_rr[k]));
            if (k > 0 && k < d_cyc.size())
                chk("rr_spacing", 32'(d_cyc[k] - d_cyc[k-1]), 32'd3);
        end

        // backpressure: (7,7,7) from requester 1 -> out1=5, out2=0
        bus.rsp_ready = 1'b0;
        request_one(1, 7, 7, 7);
        set_ops(3, 1, 2, 3);
        bus.req_valid[3] = 1'b1;
        @(negedge clk); #1;
        chk("bp_eval_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_id",    32'(bus.rsp_id), 32'd1);
            chk("bp_rsp_out1",  32'(bus.rsp_out1), 32'd5);
            chk("bp_rsp_out2",  32'(bus.rsp_out2), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        sync();
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        sync();
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_next_grant",  32'(bus.req_ready), 32'h8);
        wait_grant(3);
        sync();
        bus.req_valid[3] = 1'b0;
        repeat (3) sync();

        // fairness: 1 held, 3 joins after first grant to 1 -> 1,3,1
        d_log.delete();
        set_ops(1, 2, 5, 6);
        set_ops(3, 4, 4, 1);
        bus.req_valid[1] = 1'b1;
        wait_log(1);
        sync();
        bus.req_valid[3] = 1'b1;
        wait_log(2);
        sync();
        bus.req_valid[3] = 1'b0;
        wait_log(3);
        sync();
        bus.req_valid[1] = 1'b0;
        repeat (4) sync();
        for (int k = 0; k < 3; k++)
            chk("fair_order", 32'(k < d_log.size() ? d_log[k] : -1), 32'(exp_fair[k]));

        // reset during EVAL drops the request
        request_one(0, 2, 2, 2);
        #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("reval_busy",      32'(bus.busy), 32'd0);
        chk("reval_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reval_eu_in1",    32'(bus.eu_in1), 32'd0);
        chk("reval_done_cnt",  32'(bus.done_cnt), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); #1;
            chk("reval_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        sync();
        request_one(2, 1, 3, 6);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("reval_next_valid", 32'(bus.rsp_valid), 32'd1);
        chk("reval_next_id",    32'(bus.rsp_id), 32'd2);
        chk("reval_next_out1",  32'(bus.rsp_out1), 32'd2);
        chk("reval_next_out2",  32'(bus.rsp_out2), 32'd7);
        sync();
        chk("reval_next_done",  32'(bus.done_cnt), 32'd1);

        // done_cnt wrap from 16'hFFFF
        force dut.done_cnt_q = 16'hFFFF;
        m_done = 16'hFFFF;
        sync();
        release dut.done_cnt_q;
        chk("wrap_preload", 32'(bus.done_cnt), 32'hFFFF);
        request_one(3, 0, 0, 1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("wrap_rsp_out1", 32'(bus.rsp_out1), 32'd1);
        sync();
        chk("wrap_done_cnt", 32'(bus.done_cnt), 32'd0);
        repeat (2) sync();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
